// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default oversampling ratio and
// parity-sense constants used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int unsigned UART_OSR_DEFAULT = 16;

  localparam bit UART_PARITY_EVEN = 1'b0;
  localparam bit UART_PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input pin. Both flops reset to
// RST_VAL so the synchronized output shows an idle level straight out of reset.
module uart_rx_sync #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver: recovers start/data/[parity]/stop frames from an oversampled
// line and emits a one-cycle write strobe (or framing-error strobe) per frame.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned OSR        = UART_OSR_DEFAULT,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = UART_PARITY_EVEN
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             baud_tick,
  input  logic             rx_data,
  output logic [WIDTH-1:0] d_out,
  output logic             fifo_we_en,
  output logic             parity_err,
  output logic             frame_err,
  output logic             rx_busy
);

  localparam int unsigned TW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] HALF_BIT = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] MID_BIT  = TW'(OSR - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic rx_s;

  rx_state_t        state_q,    state_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic             par_bad_q,  par_bad_d;
  logic [WIDTH-1:0] dout_q,     dout_d;
  logic             we_q,       we_d;
  logic             perr_q,     perr_d;
  logic             ferr_q,     ferr_d;
  logic             busy_q,     busy_d;

  uart_rx_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (rx_data),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_bad_q  <= 1'b0;
      dout_q     <= '0;
      we_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_bad_q  <= par_bad_d;
      dout_q     <= dout_d;
      we_q       <= we_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  // Strobes are registered on the stop-bit mid-sample tick, so they appear
  // exactly one clk later together with the updated d_out and busy drop.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_bad_d  = par_bad_q;
    dout_d     = dout_q;
    we_d       = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end

        START: begin
          if (tick_cnt_q == HALF_BIT) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_cnt_d = '0;
              par_bad_d = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        DATA: begin
          if (tick_cnt_q == MID_BIT) begin
            tick_cnt_d        = '0;
            data_d[bit_cnt_q] = rx_s;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = PARITY_EN ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        PARITY: begin
          if (tick_cnt_q == MID_BIT) begin
            tick_cnt_d = '0;
            par_bad_d  = rx_s ^ ((^data_q) ^ PARITY_ODD);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        STOP: begin
          if (tick_cnt_q == MID_BIT) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              dout_d  = data_q;
              we_d    = 1'b1;
              perr_d  = PARITY_EN & par_bad_q;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d    = IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign d_out      = dout_q;
  assign fifo_we_en = we_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench: two receivers (no parity / even parity) fed by serial frames;
// each frame's expected outcome is queued and matched against the DUT strobes.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  localparam int unsigned W       = 8;
  localparam int unsigned OSR     = 16;
  localparam int unsigned TPB     = 4;
  localparam int unsigned BIT_CLK = OSR * TPB;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         baud_tick = 1'b0;
  logic         rx0 = 1'b1, rx1 = 1'b1;
  logic [W-1:0] dout0, dout1;
  logic         we0, we1, pe0, pe1, fe0, fe1, busy0, busy1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    bit           ferr;
    logic [W-1:0] data;
    bit           perr;
    int unsigned  t0;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  logic [W-1:0] last0 = '0;
  logic [W-1:0] last1 = '0;

  uart_rx_oversample #(
    .WIDTH(W), .OSR(OSR), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) dut0 (
    .clk(clk), .rstn(rstn), .baud_tick(baud_tick), .rx_data(rx0),
    .d_out(dout0), .fifo_we_en(we0), .parity_err(pe0), .frame_err(fe0), .rx_busy(busy0)
  );

  uart_rx_oversample #(
    .WIDTH(W), .OSR(OSR), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut1 (
    .clk(clk), .rstn(rstn), .baud_tick(baud_tick), .rx_data(rx1),
    .d_out(dout1), .fifo_we_en(we1), .parity_err(pe1), .frame_err(fe1), .rx_busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      repeat (TPB - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int unsigned act, input int unsigned lo,
                      input int unsigned hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Nominal strobe time: start + data + parity bits plus half a stop bit.
  task automatic score(input int d, input logic we, input logic fe, input logic pe,
                       input logic [W-1:0] dout);
    exp_t        e;
    int unsigned nom;
    nom = BIT_CLK * (1 + W + ((d == 1) ? 1 : 0)) + BIT_CLK / 2;
    chk1($sformatf("d%0d_we_fe_exclusive", d), we & fe, 1'b0);
    if (pe && !we) chk1($sformatf("d%0d_perr_with_we", d), we, 1'b1);
    if (!(we || fe)) return;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL d%0d_unexpected_strobe actual we=%b fe=%b expected none", d, we, fe);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk1($sformatf("d%0d_frame_err", d), fe, e.ferr);
    if (e.ferr) begin
      chkw($sformatf("d%0d_dout_hold", d), dout, (d == 0) ? last0 : last1);
    end else begin
      chkw($sformatf("d%0d_data", d), dout, e.data);
      chk1($sformatf("d%0d_parity_err", d), pe, e.perr);
      if (d == 0) last0 = e.data; else last1 = e.data;
    end
    chkn($sformatf("d%0d_latency", d), cyc - e.t0, nom, nom + 8);
  endtask

  always @(negedge clk) if (we0 || fe0 || pe0) score(0, we0, fe0, pe0, dout0);
  always @(negedge clk) if (we1 || fe1 || pe1) score(1, we1, fe1, pe1, dout1);

  task automatic drive_bit(input int d, input logic v, input int unsigned nbits);
    if (d == 0) rx0 = v; else rx1 = v;
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  task automatic send(input int d, input logic [W-1:0] data, input bit par_ok,
                      input bit stop, input int unsigned break_bits);
    exp_t e;
    logic pbit;
    pbit   = (^data) ^ ~par_ok;
    e.ferr = !stop;
    e.data = data;
    e.perr = (d == 1) && !par_ok;
    e.t0   = cyc;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    drive_bit(d, 1'b0, 1);
    for (int i = 0; i < W; i++) begin
      if (d == 0) rx0 = data[i]; else rx1 = data[i];
      if (i == 2) chk1($sformatf("d%0d_busy_mid_frame", d), (d == 0) ? busy0 : busy1, 1'b1);
      drive_bit(d, data[i], 1);
    end
    if (d == 1) drive_bit(d, pbit, 1);
    drive_bit(d, stop, 1);
    if (!stop) begin
      if (break_bits > 0) drive_bit(d, 1'b0, break_bits);
      drive_bit(d, 1'b1, 1);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chkn({name, "_q0_empty"}, q0.size(), 0, 0);
    chkn({name, "_q1_empty"}, q1.size(), 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chkw("rst_dout0", dout0, '0);
    chk1("rst_we0", we0, 1'b0);
    chk1("rst_fe0", fe0, 1'b0);
    chk1("rst_pe0", pe0, 1'b0);
    chk1("rst_busy0", busy0, 1'b0);
    chkw("rst_dout1", dout1, '0);
    chk1("rst_busy1", busy1, 1'b0);
    rstn = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);

    send(0, 8'hA5, 1'b1, 1'b1, 0);
    drive_bit(0, 1'b1, 1);
    drain("t1");

    rx0 = 1'b0;
    repeat (4 * TPB) @(negedge clk);
    chk1("glitch_busy_high", busy0, 1'b1);
    rx0 = 1'b1;
    repeat (10 * TPB) @(negedge clk);
    chk1("glitch_busy_low", busy0, 1'b0);
    drive_bit(0, 1'b1, 1);

    send(0, 8'h3C, 1'b1, 1'b0, 20);
    send(0, 8'h5A, 1'b1, 1'b1, 0);
    drive_bit(0, 1'b1, 1);
    drain("t3");

    send(1, 8'h07, 1'b0, 1'b1, 0);
    drive_bit(1, 1'b1, 1);
    send(1, 8'h07, 1'b1, 1'b1, 0);
    drive_bit(1, 1'b1, 1);

    send(0, 8'h00, 1'b1, 1'b1, 0);
    send(0, 8'hFF, 1'b1, 1'b1, 0);
    send(1, 8'h00, 1'b1, 1'b1, 0);
    send(1, 8'hFF, 1'b0, 1'b1, 0);
    drive_bit(0, 1'b1, 1);
    drain("t5");

    drive_bit(0, 1'b0, 1);
    drive_bit(0, 1'b1, 1);
    drive_bit(0, 1'b0, 2);
    repeat (BIT_CLK / 2) @(negedge clk);
    rstn = 1'b0;
    last0 = '0;
    last1 = '0;
    repeat (10) @(negedge clk);
    chk1("rst_mid_busy", busy0, 1'b0);
    chkw("rst_mid_dout", dout0, '0);
    rx0 = 1'b1;
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk1("rst_mid_busy_after", busy0, 1'b0);
    drive_bit(0, 1'b1, 2);
    send(0, 8'h42, 1'b1, 1'b1, 0);
    drive_bit(0, 1'b1, 1);
    drain("t6");

    for (int n = 0; n < 40; n++) begin
      int d;
      bit st;
      d  = n % 2;
      st = ($urandom_range(0, 7) != 0);
      send(d, W'($urandom), ($urandom_range(0, 3) != 0), st, $urandom_range(0, 3));
      drive_bit(d, 1'b1, $urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drive_bit(0, 1'b1, 1);
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
